// File: rtl/mpt_tlb.sv
// mpt_tlb: fully associative permission TLB for the MPT walker.
// Each entry caches {SDID, SPA tag, size, permissions}. The TLB supports
// SDID-selective or full flush, and a registered permission check.
// Optional build macro MPT_TLB_PERF_CNT_EN adds saturating hit/miss counters.
module mpt_tlb #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned PLEN        = 56,
  parameter int unsigned SDID_LEN    = 6,
  parameter int unsigned MID_SHIFT   = 21
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                lookup_valid_i,
  input  logic [SDID_LEN-1:0] lookup_sdid_i,
  input  logic [PLEN-1:0]     lookup_spa_i,
  input  logic [1:0]          lookup_access_i,
  output logic                lookup_done_o,
  output logic                lookup_hit_o,
  output logic [1:0]          lookup_perm_o,
  output logic                lookup_allowed_o,
  input  logic                fill_valid_i,
  input  logic [SDID_LEN-1:0] fill_sdid_i,
  input  logic [PLEN-1:0]     fill_spa_i,
  input  logic [1:0]          fill_size_i,
  input  logic [1:0]          fill_perm_i,
  input  logic                flush_i,
  input  logic                flush_sdid_en_i,
`ifdef MPT_TLB_PERF_CNT_EN
  input  logic [SDID_LEN-1:0] flush_sdid_i,
  output logic [31:0]         perf_hits_o,
  output logic [31:0]         perf_misses_o
`else
  input  logic [SDID_LEN-1:0] flush_sdid_i
`endif
);

  localparam int unsigned IW       = $clog2(NUM_ENTRIES);
  localparam int unsigned TW       = PLEN - 12;
  localparam int unsigned MID_BITS = MID_SHIFT - 12;
  localparam int unsigned GIG_BITS = 30 - 12;

  // Tag bits that take part in a compare for a given page size
  function automatic logic [TW-1:0] size_mask(input logic [1:0] size);
    logic [TW-1:0] m;
    m = '1;
    case (size)
      2'd1:    m = m << MID_BITS;
      2'd2:    m = m << GIG_BITS;
      default: m = '1;
    endcase
    return m;
  endfunction

  // Permission check: 0=NONE 1=READ 2=WRITE 3=EXEC vs 0=DIS 1=RX 2=RW 3=RWX
  function automatic logic perm_ok(input logic [1:0] access, input logic [1:0] perm);
    logic ok;
    case (access)
      2'd1:    ok = (perm != 2'd0);
      2'd2:    ok = perm[1];
      2'd3:    ok = perm[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [SDID_LEN-1:0]    sdid_q [NUM_ENTRIES];
  logic [TW-1:0]          tag_q  [NUM_ENTRIES];
  logic [1:0]             size_q [NUM_ENTRIES];
  logic [1:0]             perm_q [NUM_ENTRIES];
  logic [IW-1:0]          ptr_q;

  logic          lk_hit;
  logic [IW-1:0] lk_idx;
  logic          lk_hit_eff;
  logic          same_hit, free_hit, fill_do, fill_adv;
  logic [IW-1:0] same_idx, free_idx, victim;
  logic [TW-1:0] fill_mask;

  // Page offsets never affect a tag compare
  logic unused_spa_low;
  assign unused_spa_low = ^{lookup_spa_i[11:0], fill_spa_i[11:0]};

  // Lookup match, lowest matching index wins
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!lk_hit && valid_q[i] && (sdid_q[i] == lookup_sdid_i) &&
          (((tag_q[i] ^ lookup_spa_i[PLEN-1:12]) & size_mask(size_q[i])) == '0)) begin
        lk_hit = 1'b1;
        lk_idx = IW'(i);
      end
    end
    lk_hit_eff = lk_hit && !flush_i;
  end

  // Fill victim: identical entry, else first free slot, else round-robin
  always_comb begin
    fill_mask = size_mask(fill_size_i);
    same_hit  = 1'b0;
    same_idx  = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!same_hit && valid_q[i] && (sdid_q[i] == fill_sdid_i) &&
          (size_q[i] == fill_size_i) &&
          (((tag_q[i] ^ fill_spa_i[PLEN-1:12]) & fill_mask) == '0)) begin
        same_hit = 1'b1;
        same_idx = IW'(i);
      end
      if (!free_hit && !valid_q[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
    fill_adv = !same_hit && !free_hit;
    victim   = same_hit ? same_idx : (free_hit ? free_idx : ptr_q);
    fill_do  = fill_valid_i && (fill_size_i != 2'd3) && !flush_i;
  end

  // Entry storage, flush and replacement pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        sdid_q[i] <= '0;
        tag_q[i]  <= '0;
        size_q[i] <= '0;
        perm_q[i] <= '0;
      end
    end else if (flush_i) begin
      if (!flush_sdid_en_i) begin
        valid_q <= '0;
        ptr_q   <= '0;
      end else begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
          if (sdid_q[i] == flush_sdid_i) valid_q[i] <= 1'b0;
        end
      end
    end else if (fill_do) begin
      valid_q[victim] <= 1'b1;
      sdid_q[victim]  <= fill_sdid_i;
      tag_q[victim]   <= fill_spa_i[PLEN-1:12];
      size_q[victim]  <= fill_size_i;
      perm_q[victim]  <= fill_perm_i;
      if (fill_adv) ptr_q <= IW'(ptr_q + 1'b1);
    end
  end

  // Registered lookup result; held while no lookup completes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lookup_done_o    <= 1'b0;
      lookup_hit_o     <= 1'b0;
      lookup_perm_o    <= 2'd0;
      lookup_allowed_o <= 1'b0;
    end else begin
      lookup_done_o <= lookup_valid_i;
      if (lookup_valid_i) begin
        lookup_hit_o     <= lk_hit_eff;
        lookup_perm_o    <= lk_hit_eff ? perm_q[lk_idx] : 2'd0;
        lookup_allowed_o <= lk_hit_eff && perm_ok(lookup_access_i, perm_q[lk_idx]);
      end
    end
  end

`ifdef MPT_TLB_PERF_CNT_EN
  // Saturating hit/miss counters, updated alongside the registered result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_hits_o   <= '0;
      perf_misses_o <= '0;
    end else if (lookup_valid_i) begin
      if (lk_hit_eff) begin
        if (perf_hits_o != '1) perf_hits_o <= perf_hits_o + 32'd1;
      end else begin
        if (perf_misses_o != '1) perf_misses_o <= perf_misses_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mpt_tlb.sv
// tb_mpt_tlb: directed plus random stimulus against a page-level model of the TLB.
module tb_mpt_tlb;
  localparam int N    = 8;
  localparam int PLEN = 56;
  localparam int SL   = 6;
  localparam int MID  = 21;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            lookup_valid_i;
  logic [SL-1:0]   lookup_sdid_i;
  logic [PLEN-1:0] lookup_spa_i;
  logic [1:0]      lookup_access_i;
  logic            lookup_done_o, lookup_hit_o, lookup_allowed_o;
  logic [1:0]      lookup_perm_o;
  logic            fill_valid_i;
  logic [SL-1:0]   fill_sdid_i;
  logic [PLEN-1:0] fill_spa_i;
  logic [1:0]      fill_size_i, fill_perm_i;
  logic            flush_i, flush_sdid_en_i;
  logic [SL-1:0]   flush_sdid_i;
`ifdef MPT_TLB_PERF_CNT_EN
  logic [31:0]     perf_hits_o, perf_misses_o;
`endif

  mpt_tlb #(.NUM_ENTRIES(N), .PLEN(PLEN), .SDID_LEN(SL), .MID_SHIFT(MID)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lookup_valid_i(lookup_valid_i), .lookup_sdid_i(lookup_sdid_i),
    .lookup_spa_i(lookup_spa_i), .lookup_access_i(lookup_access_i),
    .lookup_done_o(lookup_done_o), .lookup_hit_o(lookup_hit_o),
    .lookup_perm_o(lookup_perm_o), .lookup_allowed_o(lookup_allowed_o),
    .fill_valid_i(fill_valid_i), .fill_sdid_i(fill_sdid_i), .fill_spa_i(fill_spa_i),
    .fill_size_i(fill_size_i), .fill_perm_i(fill_perm_i),
    .flush_i(flush_i), .flush_sdid_en_i(flush_sdid_en_i),
`ifdef MPT_TLB_PERF_CNT_EN
    .flush_sdid_i(flush_sdid_i),
    .perf_hits_o(perf_hits_o), .perf_misses_o(perf_misses_o)
`else
    .flush_sdid_i(flush_sdid_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: entries keep the whole fill address and page size
  bit              m_valid [N];
  int              m_sdid  [N];
  longint unsigned m_spa   [N];
  int              m_size  [N];
  int              m_perm  [N];
  int              m_ptr;
  bit              e_hit, e_allow;
  int              e_perm;
  longint unsigned m_hits, m_misses;

  function automatic int page_shift(input int s);
    return (s == 0) ? 12 : ((s == 1) ? MID : 30);
  endfunction

  function automatic bit same_page(input longint unsigned a, input longint unsigned b, input int s);
    return (a >> page_shift(s)) == (b >> page_shift(s));
  endfunction

  function automatic bit may_access(input int acc, input int perm);
    case (acc)
      1: return perm != 0;
      2: return perm == 2 || perm == 3;
      3: return perm == 1 || perm == 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_ptr = 0; e_hit = 0; e_perm = 0; e_allow = 0; m_hits = 0; m_misses = 0;
  endtask

  task automatic idle_inputs();
    lookup_valid_i = 0; lookup_sdid_i = '0; lookup_spa_i = '0; lookup_access_i = '0;
    fill_valid_i = 0; fill_sdid_i = '0; fill_spa_i = '0; fill_size_i = '0; fill_perm_i = '0;
    flush_i = 0; flush_sdid_en_i = 0; flush_sdid_i = '0;
  endtask

  // One clock of combined stimulus, model update and output check
  task automatic cyc(input bit lv, input int lsd, input longint unsigned lspa, input int lacc,
                     input bit fv, input int fsd, input longint unsigned fspa, input int fsz,
                     input int fperm, input bit fl, input bit flen, input int flsd,
                     input string tag);
    int victim;
    @(negedge clk_i);
    lookup_valid_i = lv; lookup_sdid_i = SL'(lsd); lookup_spa_i = PLEN'(lspa);
    lookup_access_i = 2'(lacc);
    fill_valid_i = fv; fill_sdid_i = SL'(fsd); fill_spa_i = PLEN'(fspa);
    fill_size_i = 2'(fsz); fill_perm_i = 2'(fperm);
    flush_i = fl; flush_sdid_en_i = flen; flush_sdid_i = SL'(flsd);
    if (lv) begin
      e_hit = 0; e_perm = 0; e_allow = 0;
      if (!fl) begin
        for (int i = 0; i < N; i++) begin
          if (!e_hit && m_valid[i] && m_sdid[i] == lsd && same_page(m_spa[i], lspa, m_size[i])) begin
            e_hit = 1; e_perm = m_perm[i]; e_allow = may_access(lacc, m_perm[i]);
          end
        end
      end
      if (e_hit) m_hits++; else m_misses++;
    end
    if (fl) begin
      for (int i = 0; i < N; i++)
        if (!flen || m_sdid[i] == flsd) m_valid[i] = 0;
      if (!flen) m_ptr = 0;
    end else if (fv && fsz != 3) begin
      victim = -1;
      for (int i = 0; i < N; i++)
        if (victim < 0 && m_valid[i] && m_sdid[i] == fsd && m_size[i] == fsz &&
            same_page(m_spa[i], fspa, fsz)) victim = i;
      for (int i = 0; i < N; i++)
        if (victim < 0 && !m_valid[i]) victim = i;
      if (victim < 0) begin
        victim = m_ptr;
        m_ptr = (m_ptr + 1) % N;
      end
      m_valid[victim] = 1; m_sdid[victim] = fsd; m_spa[victim] = fspa;
      m_size[victim] = fsz; m_perm[victim] = fperm;
    end
    @(posedge clk_i);
    #1;
    check({tag, ".done"},    64'(lookup_done_o),    64'(lv));
    check({tag, ".hit"},     64'(lookup_hit_o),     64'(e_hit));
    check({tag, ".perm"},    64'(lookup_perm_o),    64'(e_perm));
    check({tag, ".allowed"}, 64'(lookup_allowed_o), 64'(e_allow));
`ifdef MPT_TLB_PERF_CNT_EN
    check({tag, ".perf_hits"},   64'(perf_hits_o),   64'(m_hits));
    check({tag, ".perf_misses"}, 64'(perf_misses_o), 64'(m_misses));
`endif
  endtask

  task automatic lookup(input int sd, input longint unsigned spa, input int acc, input string tag);
    cyc(1, sd, spa, acc, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic fill(input int sd, input longint unsigned spa, input int sz, input int perm);
    cyc(0, 0, 0, 0, 1, sd, spa, sz, perm, 0, 0, 0, "fill");
  endtask

  task automatic flush(input bit en, input int sd);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, en, sd, "flush");
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst.done",    64'(lookup_done_o),    64'd0);
    check("rst.hit",     64'(lookup_hit_o),     64'd0);
    check("rst.perm",    64'(lookup_perm_o),    64'd0);
    check("rst.allowed", 64'(lookup_allowed_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1;

    // Cold miss, then a 4K RX page
    lookup(3, 64'h1000, 1, "cold");
    fill(3, 64'h5000, 0, 1);
    lookup(3, 64'h5ABC, 3, "rx_exec");
    lookup(3, 64'h5ABC, 2, "rx_write");
    lookup(4, 64'h5ABC, 3, "rx_other_sdid");
    lookup(3, 64'h5ABC, 0, "rx_none");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "hold");

    // Mid-size page boundary
    fill(3, 64'h40_0000, 1, 2);
    lookup(3, 64'h5F_F000, 1, "mid_in");
    lookup(3, 64'h60_0000, 1, "mid_out");
    fill(3, 64'h4000_0000, 2, 3);
    lookup(3, 64'h7FFF_F123, 2, "gig_in");
    lookup(3, 64'h8000_0000, 2, "gig_out");
    fill(3, 64'h9000, 3, 3);
    lookup(3, 64'h9000, 1, "rsvd_size");

    // Round-robin replacement after the table fills
    flush(0, 0);
    for (int i = 0; i < 9; i++) fill(5, 64'h10000 + 64'(i) * 64'h1000, 0, 3);
    lookup(5, 64'h10000, 1, "rr_first");
    lookup(5, 64'h18000, 1, "rr_ninth");
    lookup(5, 64'h11000, 1, "rr_second");
    fill(5, 64'h1A000, 0, 3);
    lookup(5, 64'h11000, 1, "rr_second_gone");
    lookup(5, 64'h1A000, 1, "rr_tenth");
    fill(5, 64'h12000, 0, 1);
    lookup(5, 64'h12000, 3, "refill_in_place");

    // SDID-selective then full flush
    flush(0, 0);
    fill(1, 64'h20000, 0, 3);
    fill(2, 64'h20000, 0, 3);
    flush(1, 1);
    lookup(1, 64'h20000, 1, "sel_flushed");
    lookup(2, 64'h20000, 1, "sel_kept");
    flush(0, 0);
    lookup(2, 64'h20000, 1, "full_flushed");

    // Simultaneous events
    cyc(1, 7, 64'h30000, 1, 1, 7, 64'h30000, 0, 3, 1, 0, 0, "flush_fill_lookup");
    lookup(7, 64'h30000, 1, "dropped_fill");
    cyc(1, 7, 64'h31000, 1, 1, 7, 64'h31000, 0, 3, 0, 0, 0, "fill_lookup");
    lookup(7, 64'h31000, 1, "fill_visible");

    // Reset while a lookup is in flight
    @(negedge clk_i);
    lookup_valid_i = 1; lookup_sdid_i = SL'(7); lookup_spa_i = PLEN'(64'h31000);
    #2 rst_ni = 0;
    model_reset();
    @(posedge clk_i);
    #1;
    check("rst_mid.done", 64'(lookup_done_o), 64'd0);
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 1;
    @(posedge clk_i);
    #1;
    check("rst_rel.done", 64'(lookup_done_o), 64'd0);
    lookup(7, 64'h31000, 1, "rst_cleared");

    // Random traffic over a small address pool to force overlaps and hits
    for (int n = 0; n < 600; n++) begin
      longint unsigned la, fa;
      la = (64'($urandom_range(0, 3)) << 30) | (64'($urandom_range(0, 3)) << 21) |
           (64'($urandom_range(0, 3)) << 12) | 64'($urandom_range(0, 4095));
      fa = (64'($urandom_range(0, 3)) << 30) | (64'($urandom_range(0, 3)) << 21) |
           (64'($urandom_range(0, 3)) << 12) | 64'($urandom_range(0, 4095));
      cyc(($urandom % 4) != 0, $urandom_range(0, 2), la, $urandom_range(0, 3),
          ($urandom % 3) == 0, $urandom_range(0, 2), fa, $urandom_range(0, 3),
          $urandom_range(0, 3), ($urandom % 25) == 0, $urandom_range(0, 1),
          $urandom_range(0, 2), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpt_tlb.md
Name: mpt_tlb

Overview:
- Parametrised, fully associative permission TLB for the Memory Protection Table walker.
- Caches `tlb_entry_t`-style results {SDID, SPA tag, PERMISSIONS} and adds per-entry page size (4 KiB / mid-size / 1 GiB).
- Adds SDID-selective flush and a registered permission check against the requested access type.
- Sits between the core's physical-access path and the MPT page-table walker. A miss triggers a walk, and the walker writes the result back through the fill port.

Parameters:
- NUM_ENTRIES, 8, number of entries (power of two, 2..64).
- PLEN, 56, physical address width (34 for RV32).
- SDID_LEN, 6, supervisor domain identifier width.
- MID_SHIFT, 21, address bit where the mid-size page begins (21 = 2 MiB for RV64, 22 = 4 MiB for RV32).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- lookup_valid_i  in  1  lookup request this cycle
- lookup_sdid_i  in  SDID_LEN  requesting domain
- lookup_spa_i  in  PLEN  supervisor physical address
- lookup_access_i  in  2  mpt_access_e (NONE/READ/WRITE/EXEC)
- lookup_done_o  out  1  result valid (registered)
- lookup_hit_o  out  1  hit flag, valid with lookup_done_o
- lookup_perm_o  out  2  mpt_permissions_e of the hit entry, 0 on miss
- lookup_allowed_o  out  1  access permitted (hit only)
- fill_valid_i  in  1  insert entry
- fill_sdid_i  in  SDID_LEN  entry SDID
- fill_spa_i  in  PLEN  entry SPA
- fill_size_i  in  2  0=4K, 1=mid (MID_SHIFT), 2=1G, 3=reserved
- fill_perm_i  in  2  entry permissions
- flush_i  in  1  flush request
- flush_sdid_en_i  in  1  1: flush only entries matching flush_sdid_i; 0: flush all
- flush_sdid_i  in  SDID_LEN  SDID to flush

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset state:
  - All valid bits cleared.
  - Replacement pointer = 0.
  - lookup_done_o, lookup_hit_o, lookup_perm_o and lookup_allowed_o all 0.
- Storage per entry: valid, SDID, tag = SPA[PLEN-1:12], size[1:0], perm[1:0].
- Match rule:
  - Entry must be valid and its SDID must equal lookup_sdid_i.
  - Tag compare by size: size 0 compares SPA[PLEN-1:12]; size 1 compares SPA[PLEN-1:MID_SHIFT]; size 2 compares SPA[PLEN-1:30].
- Lookup latency: exactly 1 cycle.
  - A request at cycle N produces lookup_done_o=1 at N+1.
  - Outputs hold their values while lookup_done_o=0. The core reads them only when lookup_done_o=1.
  - Back-to-back lookups are supported every cycle.
- Multiple matches (overlapping sizes): the lowest index wins.
- lookup_allowed_o:
  - READ: allowed when perm != DISALLOWED.
  - WRITE: allowed when perm ∈ {ALLOW_RW, ALLOW_RWX}.
  - EXEC: allowed when perm ∈ {ALLOW_RX, ALLOW_RWX}.
  - NONE: always 0.
  - Always 0 on a miss.
- Fill: written at the clock edge and visible to lookups starting the next cycle.
- Fill victim selection, in priority order:
  - An existing valid entry with identical {SDID, tag masked by fill size, size} is overwritten in place; the pointer is not advanced.
  - Otherwise the lowest-index invalid entry; the pointer is not advanced.
  - Otherwise the entry at the round-robin pointer; the pointer then increments modulo NUM_ENTRIES (wraps to 0 after NUM_ENTRIES-1).
- Fill address: fill_spa_i low bits below the size boundary are stored but ignored in compares.
- fill_size_i=3: the fill is dropped with no state change.
- Flush: completes in a single cycle.
  - flush_sdid_en_i=0 clears all valid bits and resets the pointer to 0.
  - flush_sdid_en_i=1 clears only entries matching flush_sdid_i; the pointer is unchanged.
- Simultaneous events:
  - Flush + fill in the same cycle: flush applies and the fill is dropped.
  - Flush + lookup in the same cycle: lookup returns miss (lookup_done_o=1, lookup_hit_o=0).
  - Fill + lookup in the same cycle: lookup sees pre-fill contents.
- Reset mid-lookup: the pending result is discarded and lookup_done_o=0 on the cycle after reset release.

Optional Feature:
- Macro: MPT_TLB_PERF_CNT_EN.
- When defined, adds outputs perf_hits_o and perf_misses_o (32 bits each).
  - Each counts completed lookups (lookup_done_o=1) by hit or miss.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
  - A full flush (flush_sdid_en_i=0) does not clear them.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then lookup SDID=3, SPA=0x0000_1000, READ → N+1: done=1, hit=0, perm=0, allowed=0.
- Fill SDID=3, SPA=0x0000_5000, size 0, ALLOW_RX; then lookup SDID=3, SPA=0x0000_5ABC:
  - EXEC → hit=1, perm=01, allowed=1.
  - WRITE → allowed=0.
  - Same lookup with SDID=4 → miss.
- Fill size 1 at SPA=0x0040_0000, ALLOW_RW; lookup 0x005F_F000 → hit, perm=10; lookup 0x0060_0000 → miss (MID_SHIFT=21).
- Fill 9 distinct 4K pages into 8 entries → entry 0 replaced (first page misses, ninth hits); tenth fill replaces entry 1.
- Fill SDIDs 1 and 2; flush with flush_sdid_en_i=1, flush_sdid_i=1 → SDID 1 misses, SDID 2 still hits; then full flush → all miss.
- Same-cycle flush + fill + lookup → lookup misses; the filled entry misses on the next lookup. With MPT_TLB_PERF_CNT_EN, check perf_misses_o increments by 1 per miss.
